// File: rtl/mcdt_wrr_arbiter.sv
// Weighted round-robin arbiter: three FIFO channels share one registered data/valid/id stream.
// Optional build macro MCDT_ARB_PRIO_EN gives channel 0 strict priority at each arbitration point.
module mcdt_wrr_arbiter #(
    parameter int DW = 32,
    parameter int WW = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] slv0_data_i,
    input  logic [DW-1:0] slv1_data_i,
    input  logic [DW-1:0] slv2_data_i,
    input  logic          slv0_req_i,
    input  logic          slv1_req_i,
    input  logic          slv2_req_i,
    input  logic          slv0_val_i,
    input  logic          slv1_val_i,
    input  logic          slv2_val_i,
    input  logic [WW-1:0] ch0_wt_i,
    input  logic [WW-1:0] ch1_wt_i,
    input  logic [WW-1:0] ch2_wt_i,
    output logic          a2s0_ack_o,
    output logic          a2s1_ack_o,
    output logic          a2s2_ack_o,
    output logic          data_val_o,
    output logic [1:0]    arb_id_o,
    output logic [DW-1:0] arb_data_o,
    output logic          busy_o
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

    state_t        state_r, state_nx_s;
    logic [1:0]    ptr_r, ptr_nx_s;
    logic [1:0]    gnt_r, gnt_nx_s;
    logic [WW-1:0] cnt_r, cnt_nx_s;
    logic [WW-1:0] wt_r, wt_nx_s;
    logic [2:0]    req_s, val_s, elig_s, ack_s;
    logic [2:0]    pick_s;
    logic          rearb_s;
    logic [DW-1:0] sel_data_s;
    logic [WW-1:0] pick_wt_s;
    logic          data_val_r;
    logic [1:0]    arb_id_r;
    logic [DW-1:0] arb_data_r;

    // Returns {found, index}: first eligible channel in order ptr, ptr+1, ptr+2 (mod 3).
    function automatic logic [2:0] arb_pick_fn(input logic [2:0] elig, input logic [1:0] ptr);
        logic [2:0] res;
        logic [2:0] sum;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            sum = {1'b0, ptr} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (elig[idx]) res = {1'b1, idx};
            else           res = res;
        end
`ifdef MCDT_ARB_PRIO_EN
        if (elig[0]) res = 3'b100;
        else         res = res;
`endif
        return res;
    endfunction

    function automatic logic [1:0] ptr_after_fn(input logic [1:0] g);
        return (g == 2'd2) ? 2'd0 : 2'(g + 2'd1);
    endfunction

    assign req_s  = {slv2_req_i, slv1_req_i, slv0_req_i};
    assign val_s  = {slv2_val_i, slv1_val_i, slv0_val_i};
    assign elig_s = req_s & {(ch2_wt_i != {WW{1'b0}}), (ch1_wt_i != {WW{1'b0}}), (ch0_wt_i != {WW{1'b0}})};
    assign pick_s = arb_pick_fn(elig_s, ptr_r);

    // Per-channel selection of head word and weight for the granted / winning channel.
    always_comb begin
        sel_data_s = {DW{1'b0}};
        pick_wt_s  = {WW{1'b0}};
        case (gnt_r)
            2'd0:    sel_data_s = slv0_data_i;
            2'd1:    sel_data_s = slv1_data_i;
            2'd2:    sel_data_s = slv2_data_i;
            default: sel_data_s = {DW{1'b0}};
        endcase
        case (pick_s[1:0])
            2'd0:    pick_wt_s = ch0_wt_i;
            2'd1:    pick_wt_s = ch1_wt_i;
            2'd2:    pick_wt_s = ch2_wt_i;
            default: pick_wt_s = {WW{1'b0}};
        endcase
    end

    // Next-state, burst bookkeeping and combinational pop strobes.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        gnt_nx_s   = gnt_r;
        cnt_nx_s   = cnt_r;
        wt_nx_s    = wt_r;
        ack_s      = 3'b000;
        rearb_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rearb_s = 1'b1;
            end
            ST_BURST: begin
                for (int i = 0; i < 3; i++) begin
                    ack_s[i] = (gnt_r == 2'(i)) & val_s[i];
                end
                if (|ack_s) begin
                    cnt_nx_s = cnt_r + WW'(1'b1);
                    rearb_s  = (cnt_r == wt_r - WW'(1'b1));
                end else begin
                    rearb_s  = ~req_s[gnt_r];
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        if (rearb_s && pick_s[2]) begin
            state_nx_s = ST_BURST;
            gnt_nx_s   = pick_s[1:0];
            wt_nx_s    = pick_wt_s;
            cnt_nx_s   = {WW{1'b0}};
`ifdef MCDT_ARB_PRIO_EN
            if (pick_s[1:0] != 2'd0) ptr_nx_s = ptr_after_fn(pick_s[1:0]);
            else                     ptr_nx_s = ptr_r;
`else
            ptr_nx_s   = ptr_after_fn(pick_s[1:0]);
`endif
        end else if (rearb_s) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            gnt_r   <= 2'd0;
            cnt_r   <= {WW{1'b0}};
            wt_r    <= {WW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            gnt_r   <= gnt_nx_s;
            cnt_r   <= cnt_nx_s;
            wt_r    <= wt_nx_s;
        end
    end

    // Output stage: capture the popped word; data/id hold when nothing is popped.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_val_r <= 1'b0;
            arb_id_r   <= 2'd0;
            arb_data_r <= {DW{1'b0}};
        end else begin
            data_val_r <= |ack_s;
            if (|ack_s) begin
                arb_id_r   <= gnt_r;
                arb_data_r <= sel_data_s;
            end else begin
                arb_id_r   <= arb_id_r;
                arb_data_r <= arb_data_r;
            end
        end
    end

    assign a2s0_ack_o = ack_s[0];
    assign a2s1_ack_o = ack_s[1];
    assign a2s2_ack_o = ack_s[2];
    assign data_val_o = data_val_r;
    assign arb_id_o   = arb_id_r;
    assign arb_data_o = arb_data_r;
    assign busy_o     = (state_r == ST_BURST);

endmodule

// File: tb/tb_mcdt_wrr_arbiter.sv
// Self-checking bench for mcdt_wrr_arbiter: FIFO-queue stimulus against a word-count burst model.
module tb_mcdt_wrr_arbiter;
    localparam int DW = 32;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [2:0]    req, val;
    logic [DW-1:0] dat [3];
    logic [WW-1:0] wt  [3];
    logic          ack0, ack1, ack2, data_val, busy;
    logic [1:0]    arb_id;
    logic [DW-1:0] arb_data;

    always #5 clk = ~clk;

    mcdt_wrr_arbiter #(.DW(DW), .WW(WW)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .slv0_data_i(dat[0]), .slv1_data_i(dat[1]), .slv2_data_i(dat[2]),
        .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
        .slv0_val_i(val[0]), .slv1_val_i(val[1]), .slv2_val_i(val[2]),
        .ch0_wt_i(wt[0]), .ch1_wt_i(wt[1]), .ch2_wt_i(wt[2]),
        .a2s0_ack_o(ack0), .a2s1_ack_o(ack1), .a2s2_ack_o(ack2),
        .data_val_o(data_val), .arb_id_o(arb_id), .arb_data_o(arb_data), .busy_o(busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] fq [3][$];
    int stall_pct = 0;
    int push_pct  = 0;
    int wt_chg_pct = 0;
    bit deep = 1'b0;
    int ids_seen[$];

    // reference model: burst = remaining word count, pointer as plain integer
    bit            m_busy = 1'b0;
    int            m_gnt = 0, m_left = 0, m_ptr = 0;
    logic          m_dv = 1'b0;
    logic [1:0]    m_id = 2'd0;
    logic [DW-1:0] m_data = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] el, input int p);
`ifdef MCDT_ARB_PRIO_EN
        if (el[0]) return 0;
`endif
        for (int k = 0; k < 3; k++) begin
            if (el[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            if (deep) begin
                while (fq[i].size() < 6) fq[i].push_back($urandom);
            end else if ($urandom_range(99) < push_pct && fq[i].size() < 8) begin
                fq[i].push_back($urandom);
            end
            if ($urandom_range(99) < wt_chg_pct) wt[i] = WW'($urandom_range(15));
            req[i] = (fq[i].size() != 0);
            val[i] = req[i] && ($urandom_range(99) >= stall_pct);
            dat[i] = req[i] ? fq[i][0] : $urandom;
        end
    endtask

    task automatic model_update();
        bit   ack, rearb;
        int   w;
        logic [2:0] el;
        ack   = m_busy && val[m_gnt];
        rearb = !m_busy;
        m_dv  = ack;
        if (ack) begin
            m_id   = 2'(m_gnt);
            m_data = dat[m_gnt];
            void'(fq[m_gnt].pop_front());
            m_left--;
            if (m_left == 0) rearb = 1'b1;
        end else if (m_busy && !req[m_gnt]) begin
            rearb = 1'b1;
        end
        if (rearb) begin
            for (int i = 0; i < 3; i++) el[i] = req[i] && (wt[i] != 0);
            w = pick(el, m_ptr);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_gnt  = w;
                m_left = int'(wt[w]);
`ifdef MCDT_ARB_PRIO_EN
                if (w != 0) m_ptr = (w + 1) % 3;
`else
                m_ptr = (w + 1) % 3;
`endif
            end else begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [2:0] exp_ack;
        @(negedge clk);
        drive();
        #1;
        for (int i = 0; i < 3; i++) exp_ack[i] = m_busy && (m_gnt == i) && val[i];
        chk("ack", {ack2, ack1, ack0}, exp_ack);
        chk("busy", busy, m_busy);
        chk("data_val", data_val, m_dv);
        chk("arb_id", arb_id, m_id);
        chk("arb_data", arb_data, m_data);
        if (data_val === 1'b1) ids_seen.push_back(int'(arb_id));
        @(posedge clk);
        model_update();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        int exp_a[6];
        rstn = 1'b0;
        req = 3'b000; val = 3'b000;
        for (int i = 0; i < 3; i++) begin dat[i] = '0; wt[i] = 4'd1; end
        #12;
        chk("rst_ack", {ack2, ack1, ack0}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_val", data_val, 1'b0);
        chk("rst_id", arb_id, 2'd0);
        chk("rst_data", arb_data, 32'd0);
        @(negedge clk); rstn = 1'b1;

        // all weights 1, two words per channel, no stalls
        for (int i = 0; i < 3; i++) begin fq[i].push_back($urandom); fq[i].push_back($urandom); end
        ids_seen.delete();
        run(12);
`ifdef MCDT_ARB_PRIO_EN
        exp_a = '{0, 0, 1, 2, 1, 2};
`else
        exp_a = '{0, 1, 2, 0, 1, 2};
`endif
        chk("seq_a_len", ids_seen.size(), 6);
        for (int k = 0; k < 6 && k < ids_seen.size(); k++) chk("seq_a_id", ids_seen[k], exp_a[k]);

        // weights 3/1/2, deep FIFOs
        wt[0] = 4'd3; wt[1] = 4'd1; wt[2] = 4'd2; deep = 1'b1;
        run(30);

        // ch1 weight 4 with only two words, then idle
        deep = 1'b0;
        for (int i = 0; i < 3; i++) fq[i].delete();
        run(4);
        wt[1] = 4'd4; fq[1].push_back($urandom); fq[1].push_back($urandom);
        run(8);

        // stalls, ch1 disabled by weight 0 while requesting
        wt[0] = 4'd2; wt[1] = 4'd0; wt[2] = 4'd3; stall_pct = 35; push_pct = 40;
        run(60);

        // fully random traffic with mid-burst weight changes
        wt_chg_pct = 10; stall_pct = 20; push_pct = 50;
        run(400);

        // asynchronous reset in the middle of a burst
        wt_chg_pct = 0; stall_pct = 0; deep = 1'b1;
        for (int i = 0; i < 3; i++) wt[i] = 4'd5;
        run(6);
        @(negedge clk);
        drive();
        #1;
        chk("pre_rst_busy", busy, m_busy);
        rstn = 1'b0;
        #1;
        chk("mid_rst_ack", {ack2, ack1, ack0}, 3'b000);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_data_val", data_val, 1'b0);
        chk("mid_rst_id", arb_id, 2'd0);
        chk("mid_rst_data", arb_data, 32'd0);
        @(posedge clk);
        #2 rstn = 1'b1;
        m_busy = 1'b0; m_gnt = 0; m_left = 0; m_ptr = 0;
        m_dv = 1'b0; m_id = 2'd0; m_data = '0;
        deep = 1'b0; push_pct = 30; stall_pct = 10;
        run(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
